alu_arbiter: RTL and testbench

//  Shares one combinational alu instance (srcA/srcB/funct -> result/zero) between two requesters,
//  e.g. the execute stage (port 0) and the address/branch-target unit (port 1).

---
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU: valid/ready request ports, one-entry operand stage, per-port result registers.
// Optional ALU_ARB_FIXED_PRIO_EN: ties always go to port 0 (default build uses round-robin tie-break).
module alu_arbiter #(
  parameter logic LAST_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [31:0] rq0_srca,
  input  logic [31:0] rq0_srcb,
  input  logic [9:0]  rq0_funct,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [31:0] rq1_srca,
  input  logic [31:0] rq1_srcb,
  input  logic [9:0]  rq1_funct,
  output logic        rs0_valid,
  input  logic        rs0_ready,
  output logic [31:0] rs0_result,
  output logic        rs0_zero,
  output logic        rs1_valid,
  input  logic        rs1_ready,
  output logic [31:0] rs1_result,
  output logic        rs1_zero
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned FW   = 10;
  localparam int unsigned SHW  = 5;

  localparam logic [FW-1:0] F_ADD  = 10'h000;
  localparam logic [FW-1:0] F_SUB  = 10'h100;
  localparam logic [FW-1:0] F_SLL  = 10'h001;
  localparam logic [FW-1:0] F_SLT  = 10'h002;
  localparam logic [FW-1:0] F_SLTU = 10'h003;
  localparam logic [FW-1:0] F_XOR  = 10'h004;
  localparam logic [FW-1:0] F_SRL  = 10'h005;
  localparam logic [FW-1:0] F_SRA  = 10'h105;
  localparam logic [FW-1:0] F_OR   = 10'h006;
  localparam logic [FW-1:0] F_AND  = 10'h007;

  typedef struct packed {
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [FW-1:0]   funct;
  } op_t;

  logic [1:0]      rq_valid;
  logic [1:0]      rs_ready;
  logic [1:0]      elig;
  logic [1:0]      gnt;
  logic            tie_pick1;
  logic            acc;
  logic            acc_own;
  op_t             acc_op;

  logic            op_v;
  logic            op_own;
  op_t             op_q;
  logic            last;

  logic [1:0]      rs_valid;
  logic [XLEN-1:0] rs_result [2];
  logic [1:0]      rs_zero;

  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic [SHW-1:0]  shamt;

  assign rq_valid = {rq1_valid, rq0_valid};
  assign rs_ready = {rs1_ready, rs0_ready};

  // A port may issue only when it has nothing in flight and no unconsumed result.
  always_comb begin
    elig = '0;
    for (int n = 0; n < 2; n++) begin
      elig[n] = rq_valid[n] & ~(op_v & (op_own == 1'(n))) &
                ~(rs_valid[n] & ~rs_ready[n]) & ~flush & resetn;
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  // last keeps tracking grants but never steers a tie here.
  assign tie_pick1 = 1'b0 & ~last;
`else
  assign tie_pick1 = ~last;
`endif

  always_comb begin
    gnt    = '0;
    gnt[0] = elig[0] & (~elig[1] | ~tie_pick1);
    gnt[1] = elig[1] & (~elig[0] |  tie_pick1);
  end

  assign rq0_ready = gnt[0];
  assign rq1_ready = gnt[1];
  assign acc       = |gnt;
  assign acc_own   = gnt[1];

  always_comb begin
    acc_op = '0;
    if (gnt[1]) acc_op = '{srca: rq1_srca, srcb: rq1_srcb, funct: rq1_funct};
    else        acc_op = '{srca: rq0_srca, srcb: rq0_srcb, funct: rq0_funct};
  end

  // Shared ALU evaluates the operand stage; unknown codes give zero.
  assign shamt = op_q.srcb[SHW-1:0];

  always_comb begin
    alu_result = '0;
    case (op_q.funct)
      F_ADD:   alu_result = op_q.srca + op_q.srcb;
      F_SUB:   alu_result = op_q.srca - op_q.srcb;
      F_SLL:   alu_result = op_q.srca << shamt;
      F_SLT:   alu_result = XLEN'($signed(op_q.srca) < $signed(op_q.srcb));
      F_SLTU:  alu_result = XLEN'(op_q.srca < op_q.srcb);
      F_XOR:   alu_result = op_q.srca ^ op_q.srcb;
      F_SRL:   alu_result = op_q.srca >> shamt;
      F_SRA:   alu_result = XLEN'($signed(op_q.srca) >>> shamt);
      F_OR:    alu_result = op_q.srca | op_q.srcb;
      F_AND:   alu_result = op_q.srca & op_q.srcb;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_v   <= 1'b0;
      op_own <= 1'b0;
      op_q   <= '0;
      last   <= LAST_INIT;
    end else if (flush) begin
      op_v   <= 1'b0;
    end else if (acc) begin
      op_v   <= 1'b1;
      op_own <= acc_own;
      op_q   <= acc_op;
      last   <= acc_own;
    end else begin
      op_v   <= 1'b0;
    end
  end

  // A landing result wins over a same-edge consume, so back-to-back results never drop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs_valid     <= '0;
      rs_zero      <= '0;
      rs_result[0] <= '0;
      rs_result[1] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (flush) begin
          rs_valid[n] <= 1'b0;
        end else if (op_v && (op_own == 1'(n))) begin
          rs_valid[n]  <= 1'b1;
          rs_result[n] <= alu_result;
          rs_zero[n]   <= alu_zero;
        end else if (rs_ready[n]) begin
          rs_valid[n] <= 1'b0;
        end
      end
    end
  end

  assign rs0_valid  = rs_valid[0];
  assign rs1_valid  = rs_valid[1];
  assign rs0_result = rs_result[0];
  assign rs1_result = rs_result[1];
  assign rs0_zero   = rs_zero[0];
  assign rs1_zero   = rs_zero[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: vector table plus hand-written arbitration, hold, flush and reset sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        rq0_valid, rq1_valid;
  logic        rq0_ready, rq1_ready;
  logic [31:0] rq0_srca, rq0_srcb, rq1_srca, rq1_srcb;
  logic [9:0]  rq0_funct, rq1_funct;
  logic        rs0_valid, rs1_valid;
  logic        rs0_ready, rs1_ready;
  logic [31:0] rs0_result, rs1_result;
  logic        rs0_zero, rs1_zero;

  // Second instance with LAST_INIT=0 for the first-tie check.
  logic        b_rq0_valid, b_rq1_valid, b_rq0_ready, b_rq1_ready;
  logic        b_rs0_valid, b_rs1_valid, b_rs0_zero, b_rs1_zero;
  logic [31:0] b_rs0_result, b_rs1_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.LAST_INIT(1'b1)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_srca(rq0_srca), .rq0_srcb(rq0_srcb), .rq0_funct(rq0_funct),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_srca(rq1_srca), .rq1_srcb(rq1_srcb), .rq1_funct(rq1_funct),
    .rs0_valid(rs0_valid), .rs0_ready(rs0_ready), .rs0_result(rs0_result), .rs0_zero(rs0_zero),
    .rs1_valid(rs1_valid), .rs1_ready(rs1_ready), .rs1_result(rs1_result), .rs1_zero(rs1_zero)
  );

  alu_arbiter #(.LAST_INIT(1'b0)) u_rr0 (
    .clk(clk), .resetn(resetn), .flush(1'b0),
    .rq0_valid(b_rq0_valid), .rq0_ready(b_rq0_ready), .rq0_srca(32'd1), .rq0_srcb(32'd2), .rq0_funct(10'h000),
    .rq1_valid(b_rq1_valid), .rq1_ready(b_rq1_ready), .rq1_srca(32'd3), .rq1_srcb(32'd4), .rq1_funct(10'h000),
    .rs0_valid(b_rs0_valid), .rs0_ready(1'b1), .rs0_result(b_rs0_result), .rs0_zero(b_rs0_zero),
    .rs1_valid(b_rs1_valid), .rs1_ready(1'b1), .rs1_result(b_rs1_result), .rs1_zero(b_rs1_zero)
  );

  typedef struct {
    bit          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [9:0]  f;
    logic [31:0] r;
    logic        z;
    string       name;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input bit port, input logic [31:0] a, input logic [31:0] b,
                              input logic [9:0] f, input logic [31:0] r, input logic z, input string name);
    mk.port = port; mk.a = a; mk.b = b; mk.f = f; mk.r = r; mk.z = z; mk.name = name;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input bit port, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [9:0] f);
    if (port == 1'b0) begin
      rq0_valid = v; rq0_srca = a; rq0_srcb = b; rq0_funct = f;
    end else begin
      rq1_valid = v; rq1_srca = a; rq1_srcb = b; rq1_funct = f;
    end
  endtask

  function automatic logic rq_rdy(input bit port);
    return port ? rq1_ready : rq0_ready;
  endfunction
  function automatic logic rs_v(input bit port);
    return port ? rs1_valid : rs0_valid;
  endfunction
  function automatic logic [31:0] rs_r(input bit port);
    return port ? rs1_result : rs0_result;
  endfunction
  function automatic logic rs_z(input bit port);
    return port ? rs1_zero : rs0_zero;
  endfunction

  // Single op on an idle arbiter with rs_ready high: accept now, result after two edges, then consumed.
  task automatic run_op(input vec_t v);
    set_rq(v.port, 1'b1, v.a, v.b, v.f);
    #1;
    chk({v.name, "_rq_ready"}, 32'(rq_rdy(v.port)), 32'd1);
    tick();
    set_rq(v.port, 1'b0, 32'd0, 32'd0, 10'd0);
    chk({v.name, "_rs_valid_early"}, 32'(rs_v(v.port)), 32'd0);
    tick();
    chk({v.name, "_rs_valid"}, 32'(rs_v(v.port)), 32'd1);
    chk({v.name, "_result"}, rs_r(v.port), v.r);
    chk({v.name, "_zero"}, 32'(rs_z(v.port)), 32'(v.z));
    chk({v.name, "_other_valid"}, 32'(rs_v(~v.port)), 32'd0);
    tick();
    chk({v.name, "_rs_consumed"}, 32'(rs_v(v.port)), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 32'd5,        32'd7,        10'h000, 32'd12,       1'b0, "add");
    vecs[1]  = mk(1'b1, 32'd3,        32'd3,        10'h100, 32'd0,        1'b1, "sub_eq");
    vecs[2]  = mk(1'b0, 32'h0000_00F0, 32'h0000_000F, 10'h004, 32'h0000_00FF, 1'b0, "xor");
    vecs[3]  = mk(1'b1, 32'd1,        32'd4,        10'h001, 32'd16,       1'b0, "sll");
    vecs[4]  = mk(1'b0, 32'hFFFF_FFFF, 32'd1,       10'h002, 32'd1,        1'b0, "slt_neg");
    vecs[5]  = mk(1'b1, 32'hFFFF_FFFF, 32'd1,       10'h003, 32'd0,        1'b1, "sltu");
    vecs[6]  = mk(1'b0, 32'h8000_0000, 32'd31,      10'h005, 32'd1,        1'b0, "srl");
    vecs[7]  = mk(1'b1, 32'h8000_0000, 32'd31,      10'h105, 32'hFFFF_FFFF, 1'b0, "sra");
    vecs[8]  = mk(1'b0, 32'h0000_00A0, 32'h0000_000A, 10'h006, 32'h0000_00AA, 1'b0, "or");
    vecs[9]  = mk(1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 10'h007, 32'h0000_00F0, 1'b0, "and");
    vecs[10] = mk(1'b0, 32'd5,        32'd7,        10'h3FF, 32'd0,        1'b1, "unknown_funct");
    vecs[11] = mk(1'b1, 32'hFFFF_FFFF, 32'd1,       10'h000, 32'd0,        1'b1, "add_wrap");

    resetn = 1'b0; flush = 1'b0;
    rs0_ready = 1'b1; rs1_ready = 1'b1;
    b_rq0_valid = 1'b0; b_rq1_valid = 1'b0;
    set_rq(1'b0, 1'b1, 32'd5, 32'd7, 10'h000);
    set_rq(1'b1, 1'b0, 32'd0, 32'd0, 10'h000);

    // Reset state, with a request pending to show ready stays low.
    #12;
    chk("reset_rq0_ready", 32'(rq0_ready), 32'd0);
    chk("reset_rs0_valid", 32'(rs0_valid), 32'd0);
    chk("reset_rs1_valid", 32'(rs1_valid), 32'd0);
    chk("reset_rs0_result", rs0_result, 32'd0);
    chk("reset_rs1_zero", 32'(rs1_zero), 32'd0);
    rq0_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // First tie on the LAST_INIT=0 instance.
    b_rq0_valid = 1'b1; b_rq1_valid = 1'b1;
    #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("tie_init0_gnt0", 32'(b_rq0_ready), 32'd1);
    chk("tie_init0_gnt1", 32'(b_rq1_ready), 32'd0);
`else
    chk("tie_init0_gnt0", 32'(b_rq0_ready), 32'd0);
    chk("tie_init0_gnt1", 32'(b_rq1_ready), 32'd1);
`endif
    tick();
    b_rq0_valid = 1'b0; b_rq1_valid = 1'b0;

    // Both ports valid with LAST_INIT=1: port 0 first, port 1 the next edge.
    set_rq(1'b0, 1'b1, 32'd3, 32'd3, 10'h100);
    set_rq(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 10'h004);
    #1;
    chk("tie_e0_rq0_ready", 32'(rq0_ready), 32'd1);
    chk("tie_e0_rq1_ready", 32'(rq1_ready), 32'd0);
    tick();
    rq0_valid = 1'b0;
    #1;
    chk("tie_e1_rq1_ready", 32'(rq1_ready), 32'd1);
    tick();
    rq1_valid = 1'b0;
    chk("tie_rs0_valid", 32'(rs0_valid), 32'd1);
    chk("tie_rs0_result", rs0_result, 32'd0);
    chk("tie_rs0_zero", 32'(rs0_zero), 32'd1);
    chk("tie_rs1_valid_early", 32'(rs1_valid), 32'd0);
    tick();
    chk("tie_rs1_valid", 32'(rs1_valid), 32'd1);
    chk("tie_rs1_result", rs1_result, 32'h0000_00FF);
    chk("tie_rs1_zero", 32'(rs1_zero), 32'd0);
    chk("tie_rs0_consumed", 32'(rs0_valid), 32'd0);
    tick();

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Held result blocks a new issue until consumed.
    rs0_ready = 1'b0;
    set_rq(1'b0, 1'b1, 32'd5, 32'd7, 10'h000);
    #1;
    chk("hold_first_ready", 32'(rq0_ready), 32'd1);
    tick();
    rq0_valid = 1'b0;
    tick();
    chk("hold_rs0_valid", 32'(rs0_valid), 32'd1);
    chk("hold_rs0_result", rs0_result, 32'd12);
    set_rq(1'b0, 1'b1, 32'd5, 32'd3, 10'h100);
    #1;
    chk("hold_blocked_ready", 32'(rq0_ready), 32'd0);
    tick();
    chk("hold_stable_valid", 32'(rs0_valid), 32'd1);
    chk("hold_stable_result", rs0_result, 32'd12);
    chk("hold_still_blocked", 32'(rq0_ready), 32'd0);
    rs0_ready = 1'b1;
    #1;
    chk("hold_release_ready", 32'(rq0_ready), 32'd1);
    tick();
    rq0_valid = 1'b0;
    chk("hold_consumed", 32'(rs0_valid), 32'd0);
    tick();
    chk("hold_second_valid", 32'(rs0_valid), 32'd1);
    chk("hold_second_result", rs0_result, 32'd2);
    chk("hold_second_zero", 32'(rs0_zero), 32'd0);
    tick();

    // Flush the cycle after accepting an op on port 1.
    set_rq(1'b1, 1'b1, 32'd1, 32'd4, 10'h001);
    #1;
    chk("flush_accept_ready", 32'(rq1_ready), 32'd1);
    tick();
    rq1_valid = 1'b0;
    flush = 1'b1;
    set_rq(1'b0, 1'b1, 32'd5, 32'd7, 10'h000);
    #1;
    chk("flush_rq0_ready", 32'(rq0_ready), 32'd0);
    chk("flush_rq1_ready", 32'(rq1_ready), 32'd0);
    tick();
    flush = 1'b0;
    rq0_valid = 1'b0;
    chk("flush_rs1_valid_a", 32'(rs1_valid), 32'd0);
    tick();
    chk("flush_rs1_valid_b", 32'(rs1_valid), 32'd0);
    run_op(vecs[3]);

    // Async reset with a held result and an op in flight.
    rs0_ready = 1'b0;
    set_rq(1'b0, 1'b1, 32'd5, 32'd7, 10'h000);
    tick();
    rq0_valid = 1'b0;
    tick();
    set_rq(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 10'h004);
    tick();
    rq1_valid = 1'b0;
    rq0_valid = 1'b1;
    chk("rst_pre_rs0_valid", 32'(rs0_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_rs0_valid", 32'(rs0_valid), 32'd0);
    chk("rst_rs1_valid", 32'(rs1_valid), 32'd0);
    chk("rst_rs0_result", rs0_result, 32'd0);
    chk("rst_rq0_ready", 32'(rq0_ready), 32'd0);
    rq0_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rs0_ready = 1'b1;
    tick();
    tick();
    chk("rst_no_replay_rs0", 32'(rs0_valid), 32'd0);
    chk("rst_no_replay_rs1", 32'(rs1_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
